// File: rtl/scoreboard_ctrl.sv
// Register hazard scoreboard: per-register pending-write counters,
// RAW/WAW issue stall, and drain sequencing for trap entry.
module scoreboard_ctrl #(
  parameter int N_REGS = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              src1_used,
  input  logic              src2_used,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [ADDR_W-1:0] src2_addr,
  input  logic              dst_wr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  input  logic              drain_req,
  output logic              stall,
  output logic              issue_ack,
  output logic [N_REGS-1:0] pending_mask,
  output logic              drain_done,
  output logic [15:0]       stall_count,
  output logic              sb_err
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N_REGS];
  logic [CNT_W-1:0] cnt_d [N_REGS];
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [15:0]      scnt_q, scnt_d;
  logic             raw_hazard;
  logic             waw_full;
  logic             all_zero_d;

  // Hazards use pre-update counters only: no same-cycle bypass.
  always_comb begin
    raw_hazard = (src1_used && cnt_q[src1_addr] != '0)
              || (src2_used && cnt_q[src2_addr] != '0);
    waw_full   = dst_wr && cnt_q[dst_addr] == CNT_MAX;
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      RUN:     stall = issue_valid && (raw_hazard || waw_full);
      DRAIN:   stall = issue_valid;
      DONE:    stall = issue_valid;
      default: stall = issue_valid;
    endcase
  end

  assign issue_ack = issue_valid && !stall;

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < N_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (issue_ack && dst_wr && dst_addr == ADDR_W'(i)) begin
        if (!(wb_valid && wb_addr == ADDR_W'(i)))
          cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (wb_valid && wb_addr == ADDR_W'(i)) begin
        if (cnt_q[i] != '0)
          cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    if (!flush && wb_valid && cnt_q[wb_addr] == '0)
      err_d = 1'b1;
  end

  always_comb begin
    all_zero_d = 1'b1;
    for (int i = 0; i < N_REGS; i++)
      if (cnt_d[i] != '0) all_zero_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (all_zero_d) state_d = DONE;
      DONE:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    done_d = (state_q == DRAIN) && (state_d == DONE);
    scnt_d = scnt_q;
    if (stall && scnt_q != 16'hFFFF)
      scnt_d = scnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      scnt_q  <= '0;
      for (int i = 0; i < N_REGS; i++)
        cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      done_q  <= done_d;
      scnt_q  <= scnt_d;
      for (int i = 0; i < N_REGS; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_REGS; i++)
      pending_mask[i] = |cnt_q[i];
  end

  assign drain_done  = done_q;
  assign stall_count = scnt_q;
  assign sb_err      = err_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed plus randomized check of scoreboard_ctrl against
// a counter-array reference model.
module tb_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, src1_used, src2_used;
  logic [2:0] src1_addr, src2_addr, dst_addr, wb_addr;
  logic       dst_wr, wb_valid, flush, drain_req;
  logic       stall, issue_ack, drain_done, sb_err;
  logic [7:0] pending_mask;
  logic [15:0] stall_count;

  int npass = 0;
  int nchk  = 0;

  int mc [8];
  int mmode;
  int mscnt;
  bit merr;
  bit mpulse;

  always #5 clk = ~clk;

  scoreboard_ctrl dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid),
    .src1_used(src1_used), .src2_used(src2_used),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .dst_wr(dst_wr), .dst_addr(dst_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .flush(flush), .drain_req(drain_req),
    .stall(stall), .issue_ack(issue_ack),
    .pending_mask(pending_mask), .drain_done(drain_done),
    .stall_count(stall_count), .sb_err(sb_err)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    issue_valid = 0; src1_used = 0; src2_used = 0;
    src1_addr = 0; src2_addr = 0; dst_wr = 0; dst_addr = 0;
    wb_valid = 0; wb_addr = 0; flush = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) mc[i] = 0;
    mmode = 0; mscnt = 0; merr = 0; mpulse = 0;
  endtask

  function automatic bit m_stall();
    if (!issue_valid) return 0;
    if (mmode != 0) return 1;
    if (src1_used && mc[src1_addr] > 0) return 1;
    if (src2_used && mc[src2_addr] > 0) return 1;
    if (dst_wr && mc[dst_addr] == 3) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = 0;
    for (int i = 0; i < 8; i++) if (mc[i] > 0) m[i] = 1'b1;
    return m;
  endfunction

  task automatic m_edge();
    int nc [8];
    int total;
    bit st, ack;
    st  = m_stall();
    ack = issue_valid && !st;
    for (int i = 0; i < 8; i++) nc[i] = flush ? 0 : mc[i];
    if (!flush) begin
      if (wb_valid && mc[wb_addr] == 0) merr = 1;
      if (!(ack && dst_wr && wb_valid && dst_addr == wb_addr)) begin
        if (ack && dst_wr) nc[dst_addr] = nc[dst_addr] + 1;
        if (wb_valid && mc[wb_addr] > 0) nc[wb_addr] = nc[wb_addr] - 1;
      end
    end
    if (st && mscnt < 65535) mscnt++;
    total = 0;
    for (int i = 0; i < 8; i++) total += nc[i];
    mpulse = 0;
    if (mmode == 0) begin
      if (drain_req) mmode = 1;
    end else if (mmode == 1) begin
      if (total == 0) begin mmode = 2; mpulse = 1; end
    end else begin
      if (!drain_req) mmode = 0;
    end
    for (int i = 0; i < 8; i++) mc[i] = nc[i];
  endtask

  task automatic cyc(string tag);
    bit st;
    #3;
    st = m_stall();
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".ack"}, 32'(issue_ack), 32'(issue_valid && !st));
    @(posedge clk);
    m_edge();
    #1;
    chk({tag, ".mask"}, 32'(pending_mask), m_mask());
    chk({tag, ".done"}, 32'(drain_done), 32'(mpulse));
    chk({tag, ".scnt"}, 32'(stall_count), 32'(mscnt));
    chk({tag, ".err"}, 32'(sb_err), 32'(merr));
  endtask

  task automatic issue_w(int d);
    idle(); issue_valid = 1; dst_wr = 1; dst_addr = 3'(d);
  endtask

  task automatic wb(int a);
    idle(); wb_valid = 1; wb_addr = 3'(a);
  endtask

  initial begin
    rst = 0; drain_req = 0; idle(); m_reset();
    #2;
    chk("rst.stall", 32'(stall), 0);
    chk("rst.ack", 32'(issue_ack), 0);
    chk("rst.mask", 32'(pending_mask), 0);
    chk("rst.done", 32'(drain_done), 0);
    chk("rst.scnt", 32'(stall_count), 0);
    chk("rst.err", 32'(sb_err), 0);
    #10 rst = 1;
    @(posedge clk); #1;

    // producer R1, dependent consumer
    issue_w(1); cyc("prod");
    chk("prod.mask02", 32'(pending_mask), 32'h02);
    idle(); issue_valid = 1; src1_used = 1; src1_addr = 1;
    cyc("cons0"); cyc("cons1");
    wb_valid = 1; wb_addr = 1; cyc("cons_wb");
    wb_valid = 0; cyc("cons_go");
    chk("cons.scnt3", 32'(stall_count), 3);

    // WAW saturation on R3
    for (int k = 0; k < 4; k++) begin issue_w(3); cyc("waw"); end
    wb_valid = 1; wb_addr = 3; cyc("waw_wb");
    wb_valid = 0; cyc("waw_go");
    for (int k = 0; k < 3; k++) begin wb(3); cyc("waw_clr"); end

    // simultaneous issue and writeback to R2
    issue_w(2); cyc("r2_iss");
    issue_w(2); wb_valid = 1; wb_addr = 2; cyc("r2_both");
    chk("r2.bit2", 32'(pending_mask[2]), 1);
    wb(2); cyc("r2_clr");

    // writeback with nothing pending
    wb(5); cyc("err_set");
    idle(); cyc("err_hold");

    // drain with R1,R4 pending
    issue_w(1); cyc("dr_i1");
    issue_w(4); cyc("dr_i4");
    idle(); drain_req = 1; cyc("dr_req");
    issue_w(6); cyc("dr_blk");
    issue_w(6); wb_valid = 1; wb_addr = 1; cyc("dr_wb1");
    issue_w(6); wb_valid = 1; wb_addr = 4; cyc("dr_wb4");
    idle(); cyc("dr_done"); cyc("dr_hold");
    drain_req = 0; cyc("dr_drop");
    issue_w(6); cyc("dr_resume");
    wb(6); cyc("dr_clr");

    // flush with all registers pending
    for (int k = 0; k < 8; k++) begin issue_w(k); cyc("fl_fill"); end
    issue_w(0); wb_valid = 1; wb_addr = 3; flush = 1; cyc("flush");
    chk("flush.mask0", 32'(pending_mask), 0);

    // async reset while draining
    issue_w(2); cyc("ar_iss");
    idle(); drain_req = 1; cyc("ar_req"); cyc("ar_drain");
    #2 rst = 0;
    #1;
    chk("ar.mask", 32'(pending_mask), 0);
    chk("ar.done", 32'(drain_done), 0);
    chk("ar.scnt", 32'(stall_count), 0);
    chk("ar.err", 32'(sb_err), 0);
    chk("ar.stall", 32'(stall), 0);
    drain_req = 0; m_reset();
    #3 rst = 1;
    @(posedge clk); #1;
    issue_w(2); cyc("ar_run");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      issue_valid = 1'($urandom);
      src1_used = 1'($urandom); src1_addr = 3'($urandom);
      src2_used = 1'($urandom); src2_addr = 3'($urandom);
      dst_wr = ($urandom % 4) != 0; dst_addr = 3'($urandom);
      wb_valid = ($urandom % 3) == 0; wb_addr = 3'($urandom);
      flush = ($urandom % 40) == 0;
      if (($urandom % 25) == 0) drain_req = ~drain_req;
      cyc("rand");
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/scoreboard_ctrl.md
# scoreboard_ctrl

Register-file hazard scoreboard and issue sequencer for the decode stage. Tracks in-flight writes to each architectural register (8×16-bit file), stalls issue on read-after-write hazards and on write-counter saturation, and drains the pipeline on request (interrupt/exception entry). Sits between the control unit/register-file read side and the writeback port.

## Interface
- N_REGS, 8, number of architectural registers
- ADDR_W, 3, register address width (log2 N_REGS)
- CNT_W, 2, per-register pending-write counter width (max pending = 2^CNT_W−1 = 3)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- issue_valid  in  1  decode has an instruction ready to issue
- src1_used / src2_used  in  1 each  instruction reads src1 / src2
- src1_addr / src2_addr  in  ADDR_W each  source register addresses
- dst_wr  in  1  instruction writes a destination register (RegWrite)
- dst_addr  in  ADDR_W  destination register address
- wb_valid  in  1  writeback retires a register write this cycle
- wb_addr  in  ADDR_W  register written by writeback
- flush  in  1  kill all in-flight instructions
- drain_req  in  1  request pipeline drain (level)
- stall  out  1  issue blocked this cycle (combinational)
- issue_ack  out  1  issue_valid && !stall (combinational)
- pending_mask  out  N_REGS  bit i = counter i nonzero (registered)
- drain_done  out  1  one-cycle pulse, drain complete
- stall_count  out  16  saturating count of cycles with stall=1
- sb_err  out  1  sticky: writeback to a register with zero pending

## Operation
- Per-register counter cnt[i], 0..3.
- FSM states: RUN, DRAIN, DONE. Reset → RUN.
- RUN: stall = issue_valid && (raw_hazard || waw_full), where raw_hazard = (src1_used && cnt[src1_addr]≠0) || (src2_used && cnt[src2_addr]≠0); waw_full = dst_wr && cnt[dst_addr]==3.
- RUN → DRAIN when drain_req=1. DRAIN: stall = issue_valid (all issue blocked). DRAIN → DONE when every cnt is 0 after the current cycle's update; DONE asserts drain_done for exactly one cycle, then → RUN if drain_req=0, else stays in DONE with drain_done low (no re-pulse) until drain_req drops.
- Counter update per cycle (issue_ack && dst_wr adds 1 to cnt[dst_addr]; wb_valid subtracts 1 from cnt[wb_addr]): same register hit by both → unchanged. wb_valid to a register with cnt=0 → counter stays 0, sb_err set until reset.
- No same-cycle bypass: a source whose counter decrements to 0 this cycle still stalls this cycle; issues next cycle.
- An instruction reading its own dst (e.g. R1←R1+R2) is checked only against pre-issue counters.
- flush: all counters → 0 next edge; issue and wb in the flush cycle ignored for counter purposes (issue_ack still computed). Flush in DRAIN → DONE next cycle.
- stall_count increments on every cycle stall=1, saturates at 0xFFFF.

## Timing
- Reset values: all cnt=0, pending_mask=0, FSM=RUN, drain_done=0, stall_count=0, sb_err=0; stall/issue_ack follow inputs combinationally (0 unless issue_valid).
- Reset mid-drain: immediately RUN, no drain_done pulse.
- stall → issue_ack: zero cycles. Counter/pending_mask visible one edge after issue/wb.
- Minimum dependent-issue spacing: producer issue at edge N, writeback at edge M → consumer issue_ack in cycle after edge M.
- drain_req asserted with cnt all 0 → DRAIN one cycle, drain_done in the following cycle (2 cycles after drain_req sampled).

## Test plan
- Reset then issue R1←… (dst_wr, dst=1): issue_ack=1, pending_mask=0x02 next cycle; consumer with src1=1 stalls until wb_valid, wb_addr=1, then issues the cycle after; stall_count=number of stalled cycles.
- Four back-to-back writes to R3, no wb: first three ack, fourth stalls (cnt=3); one wb to R3 → fourth issues next cycle, cnt stays 3.
- Same-cycle issue dst=R2 and wb R2 with cnt=1: cnt stays 1, pending_mask bit 2 stays set.
- wb_valid to R5 with cnt=0: sb_err=1 and persists; counters unchanged.
- drain_req with R1,R4 pending: issue blocked; after both wb, drain_done pulses once; drain_req drop → RUN, issue resumes.
- flush with pending_mask=0xFF and simultaneous wb: pending_mask=0x00 next cycle, sb_err unchanged; async rst low mid-DRAIN → all outputs reset values immediately.
